// File: rtl/alu_issue_if.sv
// alu_issue_if: handshake and operand bundle between register read, the issue stage and execute.
interface alu_issue_if #(parameter int N = 32);
    logic          in_valid;
    logic          in_ready;
    logic [31:0]   instr;
    logic [N-1:0]  rs1_data;
    logic [N-1:0]  rs2_data;
    logic          flush;
    logic          out_valid;
    logic          out_ready;
    logic [N-1:0]  alu_a;
    logic [N-1:0]  alu_b;
    logic [3:0]    alu_sel;
    logic          is_branch;
    logic          illegal;
    logic [15:0]   issued_cnt;
    modport master (
        output in_valid, instr, rs1_data, rs2_data, flush, out_ready,
        input  in_ready, out_valid, alu_a, alu_b, alu_sel, is_branch, illegal, issued_cnt
    );
    modport slave (
        input  in_valid, instr, rs1_data, rs2_data, flush, out_ready,
        output in_ready, out_valid, alu_a, alu_b, alu_sel, is_branch, illegal, issued_cnt
    );
endinterface

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: ID/EX register that decodes RV32 ALU work into operands and a 4-bit ALU select.
module alu_issue_stage #(
    parameter int N = 32
) (
    input  logic       clk,
    input  logic       rst,
    alu_issue_if.slave bus
);
    logic [6:0]   w_op;
    logic [2:0]   w_f3;
    logic [6:0]   w_f7;
    logic [N-1:0] w_imm_i;
    logic [N-1:0] w_imm_s;
    logic [3:0]   w_sel;
    logic [1:0]   w_bsrc;
    logic         w_br;
    logic         w_ill;
    logic [N-1:0] w_b;
    logic         w_cap;
    logic         r_valid;
    logic [N-1:0] r_a;
    logic [N-1:0] r_b;
    logic [3:0]   r_sel;
    logic         r_br;
    logic         r_ill;
    logic [15:0]  r_cnt;

    assign w_op    = bus.instr[6:0];
    assign w_f3    = bus.instr[14:12];
    assign w_f7    = bus.instr[31:25];
    assign w_imm_i = {{(N-12){bus.instr[31]}}, bus.instr[31:20]};
    assign w_imm_s = {{(N-12){bus.instr[31]}}, bus.instr[31:25], bus.instr[11:7]};

    // w_bsrc: 0 zero, 1 rs2, 2 I-immediate, 3 S-immediate
    always_comb begin
        w_sel  = 4'b1111;
        w_bsrc = 2'd0;
        w_br   = 1'b0;
        case (w_op)
            7'b0110011: begin
                w_sel  = (w_f3 == 3'b000 && w_f7 == 7'h00) ? 4'b0010 :
                         (w_f3 == 3'b000 && w_f7 == 7'h20) ? 4'b0110 :
                         (w_f3 == 3'b111) ? 4'b0000 :
                         (w_f3 == 3'b110) ? 4'b0001 : 4'b1111;
                w_bsrc = 2'd1;
            end
            7'b0010011: begin
                w_sel  = (w_f3 == 3'b000) ? 4'b0010 :
                         (w_f3 == 3'b111) ? 4'b0000 :
                         (w_f3 == 3'b110) ? 4'b0001 : 4'b1111;
                w_bsrc = 2'd2;
            end
            7'b0000011: begin
                w_sel  = 4'b0010;
                w_bsrc = 2'd2;
            end
            7'b0100011: begin
                w_sel  = 4'b0010;
                w_bsrc = 2'd3;
            end
            7'b1100011: begin
                w_br   = (w_f3 == 3'b000 || w_f3 == 3'b001);
                w_sel  = w_br ? 4'b0110 : 4'b1111;
                w_bsrc = 2'd1;
            end
            default: w_sel = 4'b1111;
        endcase
    end

    assign w_ill = (w_sel == 4'b1111);
    assign w_b   = w_ill ? '0 :
                   (w_bsrc == 2'd1) ? bus.rs2_data :
                   (w_bsrc == 2'd2) ? w_imm_i :
                   (w_bsrc == 2'd3) ? w_imm_s : '0;

    assign bus.in_ready = !r_valid || bus.out_ready;
    assign w_cap        = bus.in_valid && bus.in_ready && !bus.flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_sel   <= 4'b0000;
            r_br    <= 1'b0;
            r_ill   <= 1'b0;
            r_cnt   <= 16'd0;
        end else begin
            r_valid <= !bus.flush && (w_cap || (r_valid && !bus.out_ready));
            if (w_cap) begin
                r_a   <= bus.rs1_data;
                r_b   <= w_b;
                r_sel <= w_sel;
                r_br  <= w_br && !w_ill;
                r_ill <= w_ill;
            end
            if (r_valid && bus.out_ready && !bus.flush)
                r_cnt <= r_cnt + 16'd1;
        end
    end

    assign bus.out_valid  = r_valid;
    assign bus.alu_a      = r_a;
    assign bus.alu_b      = r_b;
    assign bus.alu_sel    = r_sel;
    assign bus.is_branch  = r_br;
    assign bus.illegal    = r_ill;
    assign bus.issued_cnt = r_cnt;
endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage: directed literal checks plus randomized traffic against a behavioural model.
module tb_alu_issue_stage;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic run = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    alu_issue_if #(.N(32)) bus ();
    alu_issue_stage #(.N(32)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct packed {
        logic [3:0]  sel;
        logic [31:0] b;
        logic        br;
        logic        ill;
    } dec_t;

    // Decode straight from the instruction table: each legal row names its op and operand B.
    function automatic dec_t ref_dec(logic [31:0] ins, logic [31:0] rs2);
        logic [6:0]  op    = ins[6:0];
        logic [2:0]  f3    = ins[14:12];
        logic [6:0]  f7    = ins[31:25];
        logic [31:0] imm_i = 32'($signed(ins[31:20]));
        logic [31:0] imm_s = 32'($signed({ins[31:25], ins[11:7]}));
        dec_t d = '{sel: 4'hF, b: 32'd0, br: 1'b0, ill: 1'b1};
        if (op == 7'h33 && f3 == 3'd0 && f7 == 7'h00) d = '{4'h2, rs2, 1'b0, 1'b0};
        if (op == 7'h33 && f3 == 3'd0 && f7 == 7'h20) d = '{4'h6, rs2, 1'b0, 1'b0};
        if (op == 7'h33 && f3 == 3'd7)                d = '{4'h0, rs2, 1'b0, 1'b0};
        if (op == 7'h33 && f3 == 3'd6)                d = '{4'h1, rs2, 1'b0, 1'b0};
        if (op == 7'h13 && f3 == 3'd0)                d = '{4'h2, imm_i, 1'b0, 1'b0};
        if (op == 7'h13 && f3 == 3'd7)                d = '{4'h0, imm_i, 1'b0, 1'b0};
        if (op == 7'h13 && f3 == 3'd6)                d = '{4'h1, imm_i, 1'b0, 1'b0};
        if (op == 7'h03)                              d = '{4'h2, imm_i, 1'b0, 1'b0};
        if (op == 7'h23)                              d = '{4'h2, imm_s, 1'b0, 1'b0};
        if (op == 7'h63 && f3 <= 3'd1)                d = '{4'h6, rs2, 1'b1, 1'b0};
        return d;
    endfunction

    logic        m_valid;
    logic [31:0] m_a;
    dec_t        m_d;
    logic [15:0] m_cnt;
    logic        m_take;

    assign m_take = bus.in_valid && (!m_valid || bus.out_ready) && !bus.flush;

    always @(posedge clk) begin
        if (rst) begin
            m_valid <= 1'b0;
            m_a     <= 32'd0;
            m_d     <= '{4'h0, 32'd0, 1'b0, 1'b0};
            m_cnt   <= 16'd0;
        end else begin
            m_valid <= bus.flush ? 1'b0 : m_take ? 1'b1 : bus.out_ready ? 1'b0 : m_valid;
            if (m_take) begin
                m_a <= bus.rs1_data;
                m_d <= ref_dec(bus.instr, bus.rs2_data);
            end
            if (m_valid && bus.out_ready && !bus.flush)
                m_cnt <= m_cnt + 16'd1;
        end
    end

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (run) begin
            cmp("m_out_valid", 32'(bus.out_valid), 32'(m_valid));
            cmp("m_in_ready", 32'(bus.in_ready), 32'(!m_valid || bus.out_ready));
            cmp("m_issued_cnt", 32'(bus.issued_cnt), 32'(m_cnt));
            cmp("m_alu_sel", 32'(bus.alu_sel), 32'(m_d.sel));
            cmp("m_alu_b", bus.alu_b, m_d.b);
            cmp("m_is_branch", 32'(bus.is_branch), 32'(m_d.br));
            cmp("m_illegal", 32'(bus.illegal), 32'(m_d.ill));
            if (!m_d.ill) cmp("m_alu_a", bus.alu_a, m_a);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] a,
                         input logic [31:0] b, input logic rdy, input logic fl);
        bus.in_valid  = v;
        bus.instr     = ins;
        bus.rs1_data  = a;
        bus.rs2_data  = b;
        bus.out_ready = rdy;
        bus.flush     = fl;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] ins = $urandom;
        logic [6:0] ops [6] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h37};
        int k = $urandom_range(0, 6);
        if (k < 6) ins[6:0] = ops[k];
        if ($urandom_range(0, 2) == 0) ins[31:25] = 7'h00;
        else if ($urandom_range(0, 1) == 0) ins[31:25] = 7'h20;
        return ins;
    endfunction

    initial begin
        drive(1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        rst = 1'b1;
        step();
        run = 1'b1;
        step();
        rst = 1'b0;
        cmp("rst_valid", 32'(bus.out_valid), 32'd0);
        cmp("rst_cnt", 32'(bus.issued_cnt), 32'd0);
        cmp("rst_sel", 32'(bus.alu_sel), 32'd0);
        cmp("rst_ab", bus.alu_a | bus.alu_b, 32'd0);

        drive(1'b1, 32'h002081B3, 32'd5, 32'd7, 1'b1, 1'b0);
        step();
        cmp("add_valid", 32'(bus.out_valid), 32'd1);
        cmp("add_sel", 32'(bus.alu_sel), 32'h2);
        cmp("add_a", bus.alu_a, 32'd5);
        cmp("add_b", bus.alu_b, 32'd7);
        drive(1'b1, 32'h402081B3, 32'd9, 32'd3, 1'b1, 1'b0);
        step();
        cmp("sub_sel", 32'(bus.alu_sel), 32'h6);
        cmp("sub_b", bus.alu_b, 32'd3);
        cmp("add_counted", 32'(bus.issued_cnt), 32'd1);
        drive(1'b1, 32'hFFF0F093, 32'd1, 32'd2, 1'b1, 1'b0);
        step();
        cmp("andi_sel", 32'(bus.alu_sel), 32'h0);
        cmp("andi_b", bus.alu_b, 32'hFFFFFFFF);
        drive(1'b1, 32'hFE20AE23, 32'd1, 32'd2, 1'b1, 1'b0);
        step();
        cmp("sw_sel", 32'(bus.alu_sel), 32'h2);
        cmp("sw_b", bus.alu_b, 32'hFFFFFFFC);
        drive(1'b1, 32'h00208063, 32'd4, 32'd4, 1'b1, 1'b0);
        step();
        cmp("beq_sel", 32'(bus.alu_sel), 32'h6);
        cmp("beq_br", 32'(bus.is_branch), 32'd1);
        cmp("b2b_cnt", 32'(bus.issued_cnt), 32'd4);

        drive(1'b1, 32'h002081B3, 32'd1, 32'd2, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            cmp("stall_ready", 32'(bus.in_ready), 32'd0);
            cmp("stall_sel", 32'(bus.alu_sel), 32'h6);
            cmp("stall_cnt", 32'(bus.issued_cnt), 32'd4);
        end
        bus.out_ready = 1'b1;
        step();
        cmp("release_sel", 32'(bus.alu_sel), 32'h2);
        cmp("release_b", bus.alu_b, 32'd2);
        cmp("release_cnt", 32'(bus.issued_cnt), 32'd5);

        drive(1'b1, 32'h402081B3, 32'd1, 32'd1, 1'b0, 1'b1);
        step();
        cmp("flush_valid", 32'(bus.out_valid), 32'd0);
        cmp("flush_cnt", 32'(bus.issued_cnt), 32'd5);

        drive(1'b1, 32'h000012B7, 32'd3, 32'd3, 1'b1, 1'b0);
        step();
        cmp("lui_ill", 32'(bus.illegal), 32'd1);
        cmp("lui_sel", 32'(bus.alu_sel), 32'hF);
        cmp("lui_b", bus.alu_b, 32'd0);
        bus.in_valid = 1'b0;
        step();
        cmp("lui_cnt", 32'(bus.issued_cnt), 32'd6);

        drive(1'b1, 32'h002081B3, 32'd8, 32'd8, 1'b0, 1'b0);
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        cmp("rst_stall_valid", 32'(bus.out_valid), 32'd0);
        cmp("rst_stall_cnt", 32'(bus.issued_cnt), 32'd0);
        cmp("rst_stall_data", bus.alu_a | bus.alu_b | 32'(bus.alu_sel), 32'd0);

        drive(1'b1, 32'h002081B3, 32'd1, 32'd1, 1'b1, 1'b0);
        for (int i = 0; i < 70000 && m_cnt != 16'hFFFF; i++) begin
            bus.rs1_data = $urandom;
            step();
        end
        cmp("wrap_pre", 32'(bus.issued_cnt), 32'hFFFF);
        step();
        cmp("wrap_zero", 32'(bus.issued_cnt), 32'h0);

        for (int i = 0; i < 4000; i++) begin
            drive($urandom_range(0, 3) != 0, rand_instr(), $urandom, $urandom,
                  $urandom_range(0, 9) < 7, $urandom_range(0, 24) == 0);
            rst = ($urandom_range(0, 199) == 0);
            step();
        end
        rst = 1'b0;
        step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
